pixel_frame_loader: RTL

- Upstream stage of the defect-detection `top_level` inference network.
- Accepts a serial 8-bit pixel stream using valid/ready and start-of-frame, then assembles one INPUT_SIZE-pixel frame into the flat vector feeding `top_level.pixel_data_flat`.
- Holds the frame stable and flags it valid until the consumer acknowledges.
- Detects short frames and restarts cleanly on a new start-of-frame.

---
 rtl/defect_pkg.sv | 15 +
 rtl/pixel_frame_loader.sv | 136 +++++++++++++
 2 files changed

// File: rtl/defect_pkg.sv
// Shared constants and types for the defect-detection inference pipeline.
// The pixel loader and top_level both import this package.
package defect_pkg;

  localparam int INPUT_SIZE  = 4096;
  localparam int HIDDEN_SIZE = 32;
  localparam int DATA_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/pixel_frame_loader.sv
// Assembles a serial pixel stream into one flat frame vector and holds it
// until the downstream network acknowledges; detects and recovers from short frames.
module pixel_frame_loader
  import defect_pkg::*;
#(
  parameter int INPUT_SIZE = defect_pkg::INPUT_SIZE,
  parameter int DATA_WIDTH = defect_pkg::DATA_WIDTH,
  localparam int CNT_W     = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             s_valid,
  input  logic [DATA_WIDTH-1:0]            s_data,
  input  logic                             s_sof,
  output logic                             s_ready,
  output logic [DATA_WIDTH*INPUT_SIZE-1:0] pixel_data_flat,
  output logic                             frame_valid,
  output logic                             frame_start,
  input  logic                             frame_ack,
  output logic                             err_short,
  output logic [15:0]                      frame_count,
  output state_t                           state_dbg
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(INPUT_SIZE - 1);

  // Handshake: a beat transfers on a rising edge where s_valid && s_ready are
  // both high; s_ready is registered and low for the whole HOLD phase.
  state_t                            state_q, state_d;
  logic [CNT_W-1:0]                  idx_q, idx_d;
  logic [DATA_WIDTH*INPUT_SIZE-1:0]  flat_q, flat_d;
  logic                              s_ready_q, s_ready_d;
  logic                              frame_valid_q, frame_valid_d;
  logic                              frame_start_q, frame_start_d;
  logic                              err_short_q, err_short_d;
  logic [15:0]                       frame_count_q, frame_count_d;

  logic                              accept;
  logic                              wr_en;
  logic [CNT_W-1:0]                  wr_idx;

  assign accept = s_valid && s_ready_q;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    s_ready_d     = s_ready_q;
    frame_valid_d = frame_valid_q;
    frame_start_d = 1'b0;
    err_short_d   = 1'b0;
    frame_count_d = frame_count_q;
    wr_en         = 1'b0;
    wr_idx        = idx_q;

    case (state_q)
      ST_IDLE: begin
        s_ready_d = 1'b1;
        if (accept && s_sof) begin
          wr_en  = 1'b1;
          wr_idx = '0;
        end
      end
      ST_FILL: begin
        if (accept) begin
          wr_en = 1'b1;
          // A new start-of-frame restarts at pixel 0; stale upper pixels stay.
          if (s_sof) begin
            wr_idx      = '0;
            err_short_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (frame_ack) begin
          frame_valid_d = 1'b0;
          s_ready_d     = 1'b1;
          idx_d         = '0;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_en) begin
      if (wr_idx == LAST_IDX) begin
        s_ready_d     = 1'b0;
        frame_valid_d = 1'b1;
        frame_start_d = 1'b1;
        frame_count_d = frame_count_q + 16'd1;
        idx_d         = wr_idx;
        state_d       = ST_HOLD;
      end else begin
        idx_d   = wr_idx + CNT_W'(1);
        state_d = ST_FILL;
      end
    end
  end

  always_comb begin
    flat_d = flat_q;
    if (wr_en) begin
      flat_d[int'(wr_idx)*DATA_WIDTH +: DATA_WIDTH] = s_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      flat_q        <= '0;
      s_ready_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_start_q <= 1'b0;
      err_short_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      flat_q        <= flat_d;
      s_ready_q     <= s_ready_d;
      frame_valid_q <= frame_valid_d;
      frame_start_q <= frame_start_d;
      err_short_q   <= err_short_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign s_ready         = s_ready_q;
  assign pixel_data_flat = flat_q;
  assign frame_valid     = frame_valid_q;
  assign frame_start     = frame_start_q;
  assign err_short       = err_short_q;
  assign frame_count     = frame_count_q;
  assign state_dbg       = state_q;

endmodule
